hba_arbiter: RTL and testbench

//  Shares one HBA bus among NUM_MASTERS requesters with round-robin arbitration.

---
 rtl/hba_arbiter.sv | 144 ++++++++++++++
 tb/tb_hba_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/hba_arbiter.sv
// hba_arbiter
//   Round-robin owner of a single shared HBA bus. The granted master's
//   rnw/select/abus/dbus drive the bus; slave xferack is steered back to that
//   master only. A watchdog ends any select that goes unacknowledged for
//   TIMEOUT cycles by faking an ack and pulsing bus_error.
// Ports
//   hba_clk, hba_reset_n          clock, async active-low reset
//   m_req/m_rnw/m_select          per-master request and bus controls
//   m_abus/m_dbus                 per-master address / write data, packed by master
//   m_grant                       registered one-hot grant
//   m_xferack, m_rdata            per-master ack, common read data (= s_dbus)
//   bus_error                     one-cycle pulse on watchdog termination
//   hba_rnw/select/abus/dbus      shared bus outputs
//   s_xferack, s_dbus             ORed slave ack / read data
module hba_arbiter #(
   parameter int NUM_MASTERS = 4,
   parameter int DBUS_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 12,
   parameter int TIMEOUT     = 255
) (
   input  logic                              hba_clk,
   input  logic                              hba_reset_n,
   input  logic [NUM_MASTERS-1:0]            m_req,
   output logic [NUM_MASTERS-1:0]            m_grant,
   input  logic [NUM_MASTERS-1:0]            m_rnw,
   input  logic [NUM_MASTERS-1:0]            m_select,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_abus,
   input  logic [NUM_MASTERS*DBUS_WIDTH-1:0] m_dbus,
   output logic [NUM_MASTERS-1:0]            m_xferack,
   output logic [DBUS_WIDTH-1:0]             m_rdata,
   output logic                              bus_error,
   output logic                              hba_rnw,
   output logic                              hba_select,
   output logic [ADDR_WIDTH-1:0]             hba_abus,
   output logic [DBUS_WIDTH-1:0]             hba_dbus,
   input  logic                              s_xferack,
   input  logic [DBUS_WIDTH-1:0]             s_dbus
);

   localparam int LW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int WW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, OWN = 2'd1, TERM = 2'd2} state_t;

   state_t                 state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [LW-1:0]          last_q, last_d;
   logic [WW-1:0]          wdog_q, wdog_d;

   logic [LW-1:0]          pick;
   logic                   found;
   logic                   sel_mux;

   // state register
   always_ff @(posedge hba_clk or negedge hba_reset_n) begin
      if (!hba_reset_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= LW'(NUM_MASTERS - 1);
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         wdog_q  <= wdog_d;
      end
   end

   // round-robin search starting just after the previous winner
   always_comb begin
      int idx;
      idx   = 0;
      found = 1'b0;
      pick  = '0;
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         idx = (int'(last_q) + k) % NUM_MASTERS;
         if (!found && m_req[idx]) begin
            found = 1'b1;
            pick  = LW'(idx);
         end
      end
   end

   // next state
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      wdog_d  = wdog_q;
      case (state_q)
         IDLE: begin
            wdog_d = '0;
            if (found) begin
               grant_d = NUM_MASTERS'(1) << pick;
               last_d  = pick;
               state_d = OWN;
            end
         end
         OWN: begin
            if (hba_select && !s_xferack) begin
               // ack on the expiry cycle takes the else branch, so it wins
               if (wdog_q == WW'(TIMEOUT - 1)) state_d = TERM;
               else                            wdog_d  = wdog_q + 1'b1;
            end else begin
               wdog_d = '0;
            end
            // release only between transfers so an in-flight select finishes
            if (!(|(m_req & grant_q)) && !hba_select) begin
               grant_d = '0;
               state_d = IDLE;
            end
         end
         TERM: begin
            wdog_d  = '0;
            state_d = OWN;
         end
         default: begin
            grant_d = '0;
            wdog_d  = '0;
            state_d = IDLE;
         end
      endcase
   end

   // outputs: AND-OR mux on the grant, so no grant means an all-zero bus
   always_comb begin
      sel_mux  = 1'b0;
      hba_rnw  = 1'b0;
      hba_abus = '0;
      hba_dbus = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         sel_mux  = sel_mux  | (m_select[i] & grant_q[i]);
         hba_rnw  = hba_rnw  | (m_rnw[i]    & grant_q[i]);
         hba_abus = hba_abus | (m_abus[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{grant_q[i]}});
         hba_dbus = hba_dbus | (m_dbus[i*DBUS_WIDTH +: DBUS_WIDTH] & {DBUS_WIDTH{grant_q[i]}});
      end
      hba_select = sel_mux & (state_q == OWN);
      bus_error  = (state_q == TERM);
      m_xferack  = grant_q & {NUM_MASTERS{((state_q == OWN) & s_xferack) | (state_q == TERM)}};
      m_rdata    = s_dbus;
      m_grant    = grant_q;
   end

endmodule

// File: tb/tb_hba_arbiter.sv
// Directed bench for hba_arbiter (4 masters, TIMEOUT=8).
module tb_hba_arbiter;
   localparam int N  = 4;
   localparam int DW = 8;
   localparam int AW = 12;

   logic          hba_clk = 1'b0;
   logic          hba_reset_n;
   logic [N-1:0]  m_req, m_grant, m_rnw, m_select, m_xferack;
   logic [N*AW-1:0] m_abus;
   logic [N*DW-1:0] m_dbus;
   logic [DW-1:0] m_rdata, hba_dbus, s_dbus;
   logic [AW-1:0] hba_abus;
   logic          bus_error, hba_rnw, hba_select, s_xferack;

   int tests = 0;
   int fails = 0;

   hba_arbiter #(.NUM_MASTERS(N), .DBUS_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(8)) dut (
      .hba_clk(hba_clk), .hba_reset_n(hba_reset_n),
      .m_req(m_req), .m_grant(m_grant), .m_rnw(m_rnw), .m_select(m_select),
      .m_abus(m_abus), .m_dbus(m_dbus), .m_xferack(m_xferack), .m_rdata(m_rdata),
      .bus_error(bus_error), .hba_rnw(hba_rnw), .hba_select(hba_select),
      .hba_abus(hba_abus), .hba_dbus(hba_dbus),
      .s_xferack(s_xferack), .s_dbus(s_dbus)
   );

   always #5 hba_clk = ~hba_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge hba_clk);
      #2;
   endtask

   initial begin
      hba_reset_n = 1'b0;
      m_req = '0; m_rnw = '0; m_select = '0;
      m_abus = {12'h4D4, 12'h3C3, 12'h2B2, 12'h1A1};
      m_dbus = {8'h44, 8'h33, 8'h22, 8'h11};
      s_xferack = 1'b0; s_dbus = '0;
      #3;
      chk("rst_grant",  32'(m_grant),    32'h0);
      chk("rst_sel",    32'(hba_select), 32'h0);
      chk("rst_berr",   32'(bus_error),  32'h0);
      tick(); tick();
      hba_reset_n = 1'b1;

      // 1: single requester m1, bus mux and ack steering
      m_req = 4'b0010;
      tick();
      chk("t1_grant", 32'(m_grant), 32'h2);
      m_select = 4'b0010; m_rnw = 4'b0010;
      #1;
      chk("t1_abus", 32'(hba_abus),   32'h2B2);
      chk("t1_dbus", 32'(hba_dbus),   32'h22);
      chk("t1_sel",  32'(hba_select), 32'h1);
      chk("t1_rnw",  32'(hba_rnw),    32'h1);
      s_xferack = 1'b1; s_dbus = 8'h5A;
      #1;
      chk("t1_ack",   32'(m_xferack), 32'h2);
      chk("t1_rdata", 32'(m_rdata),   32'h5A);
      tick();
      s_xferack = 1'b0; m_select = '0; m_rnw = '0; m_req = '0;
      tick();
      chk("t1_rel", 32'(m_grant), 32'h0);

      // 2: all request after reset, round-robin order with idle gaps
      hba_reset_n = 1'b0; #1; hba_reset_n = 1'b1;
      m_req = 4'b1111;
      for (int i = 0; i < N; i++) begin
         tick();
         chk("t2_grant", 32'(m_grant), 32'(1 << i));
         m_select = N'(1 << i); s_xferack = 1'b1;
         #1;
         chk("t2_ack", 32'(m_xferack), 32'(1 << i));
         tick();
         m_select = '0; s_xferack = 1'b0; m_req[i] = 1'b0;
         tick();
         chk("t2_gap", 32'(m_grant), 32'h0);
      end

      // 3: m2 drops req mid-transfer, release waits for select low
      m_req = 4'b0100;
      tick();
      chk("t3_grant", 32'(m_grant), 32'h4);
      m_select = 4'b0100;
      tick();
      m_req = '0;
      tick();
      chk("t3_hold1", 32'(m_grant), 32'h4);
      tick();
      chk("t3_hold2", 32'(m_grant), 32'h4);
      s_xferack = 1'b1;
      tick();
      s_xferack = 1'b0; m_select = '0;
      tick();
      chk("t3_idle", 32'(m_grant), 32'h0);

      // 4: watchdog termination after 8 unacked select cycles
      m_req = 4'b0001;
      tick();
      chk("t4_grant", 32'(m_grant), 32'h1);
      m_select = 4'b0001;
      for (int i = 0; i < 7; i++) tick();
      chk("t4_pre_berr", 32'(bus_error),  32'h0);
      chk("t4_pre_sel",  32'(hba_select), 32'h1);
      tick();
      chk("t4_berr", 32'(bus_error),  32'h1);
      chk("t4_sel",  32'(hba_select), 32'h0);
      chk("t4_ack",  32'(m_xferack),  32'h1);
      m_select = '0;
      tick();
      chk("t4_post_berr", 32'(bus_error), 32'h0);
      chk("t4_post_ack",  32'(m_xferack), 32'h0);
      chk("t4_post_gnt",  32'(m_grant),   32'h1);
      m_req = '0;
      tick();

      // 5: ack on the expiry cycle beats the watchdog
      m_req = 4'b0010;
      tick();
      chk("t5_grant", 32'(m_grant), 32'h2);
      m_select = 4'b0010;
      for (int i = 0; i < 7; i++) tick();
      s_xferack = 1'b1;
      #1;
      chk("t5_ack",  32'(m_xferack), 32'h2);
      chk("t5_berr", 32'(bus_error), 32'h0);
      tick();
      s_xferack = 1'b0;
      #1;
      chk("t5_noterm_berr", 32'(bus_error),  32'h0);
      chk("t5_noterm_sel",  32'(hba_select), 32'h1);
      chk("t5_noterm_ack",  32'(m_xferack),  32'h0);
      m_select = '0; m_req = '0;
      tick();

      // 6: async reset mid-transfer, then m0 wins
      m_req = 4'b1000;
      tick();
      chk("t6_grant", 32'(m_grant), 32'h8);
      m_select = 4'b1000;
      tick();
      hba_reset_n = 1'b0;
      #1;
      chk("t6_rst_grant", 32'(m_grant),    32'h0);
      chk("t6_rst_sel",   32'(hba_select), 32'h0);
      chk("t6_rst_berr",  32'(bus_error),  32'h0);
      chk("t6_rst_abus",  32'(hba_abus),   32'h0);
      m_select = '0; m_req = 4'b1111;
      #1;
      hba_reset_n = 1'b1;
      tick();
      chk("t6_first", 32'(m_grant), 32'h1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
